// File: rtl/depackager.sv
// Receive-side frame depackager: hunts for the header byte, gathers ADC_COUNT
// big-endian samples and presents them as parallel words with a frame strobe.
module depackager #(
  parameter int unsigned ADC_DATA_WIDTH = 16,
  parameter int unsigned ADC_COUNT      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  HEADER         = 8'hFF
) (
  input  logic                      mclkin,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_0,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_1,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_2,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_3,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_4,
  output logic [ADC_DATA_WIDTH-1:0] data_adc_5,
  output logic                      frame_valid,
  output logic                      frame_error,
  output logic [15:0]               frame_count
);

  localparam int unsigned NBYTES = 2 * ADC_COUNT;
  localparam int unsigned IW     = $clog2(NBYTES);
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] ILAST = IW'(NBYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {HUNT, PAYLOAD, COMMIT} state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             idx;
  logic [TW-1:0]             tcnt;
  logic                      xfer;
  logic                      timeout;
  logic [ADC_DATA_WIDTH-1:0] stage  [ADC_COUNT];
  logic [ADC_DATA_WIDTH-1:0] data_q [ADC_COUNT];

  assign xfer = rx_valid && rx_ready;

  // rx_ready is gated by the reset input so it reads 0 while held in reset.
  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    rx_ready = rst && (state != COMMIT);
    case (state)
      HUNT:    if (xfer && rx_data == HEADER) state_nx = PAYLOAD;
      PAYLOAD: begin
        if (xfer) begin
          if (idx == ILAST) state_nx = COMMIT;
        end else if (tcnt == TLAST) begin
          timeout  = 1'b1;
          state_nx = HUNT;
        end
      end
      COMMIT:  state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge mclkin or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      idx         <= '0;
      tcnt        <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
      for (int unsigned i = 0; i < ADC_COUNT; i++) begin
        stage[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state       <= state_nx;
      frame_valid <= (state == COMMIT);
      frame_error <= timeout;
      case (state)
        HUNT: begin
          if (xfer && rx_data == HEADER) begin
            idx  <= '0;
            tcnt <= '0;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            tcnt <= '0;
            idx  <= idx + 1'b1;
            if (!idx[0]) stage[idx[IW-1:1]][ADC_DATA_WIDTH-1 -: 8] <= rx_data;
            else         stage[idx[IW-1:1]][7:0]                  <= rx_data;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < ADC_COUNT; i++) data_q[i] <= stage[i];
          frame_count <= frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_adc_0 = data_q[0];
  assign data_adc_1 = data_q[1];
  assign data_adc_2 = data_q[2];
  assign data_adc_3 = data_q[3];
  assign data_adc_4 = data_q[4];
  assign data_adc_5 = data_q[5];

endmodule

// File: tb/tb_depackager.sv
// Directed bench for depackager: nominal, garbage, gaps, timeout,
// back-to-back and mid-frame reset scenarios.
module tb_depackager;

  localparam int TO = 1024;

  logic        mclkin = 1'b0;
  logic        rst    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_ready;
  logic [15:0] data_adc_0, data_adc_1, data_adc_2, data_adc_3, data_adc_4, data_adc_5;
  logic        frame_valid, frame_error;
  logic [15:0] frame_count;

  logic [15:0] dout [6];
  logic [15:0] fw   [6];
  logic [15:0] prev [6];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int fv_n  = 0;
  int fe_n  = 0;
  int fv_t1 = 0;
  int fv_t2 = 0;

  depackager #(
    .ADC_DATA_WIDTH(16),
    .ADC_COUNT(6),
    .TIMEOUT_CYCLES(TO),
    .HEADER(8'hFF)
  ) dut (
    .mclkin(mclkin), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready),
    .data_adc_0(data_adc_0), .data_adc_1(data_adc_1), .data_adc_2(data_adc_2),
    .data_adc_3(data_adc_3), .data_adc_4(data_adc_4), .data_adc_5(data_adc_5),
    .frame_valid(frame_valid), .frame_error(frame_error), .frame_count(frame_count)
  );

  assign dout[0] = data_adc_0;
  assign dout[1] = data_adc_1;
  assign dout[2] = data_adc_2;
  assign dout[3] = data_adc_3;
  assign dout[4] = data_adc_4;
  assign dout[5] = data_adc_5;

  always #5 mclkin = ~mclkin;

  always @(negedge mclkin) begin
    cyc = cyc + 1;
    if (frame_valid) begin
      fv_n  = fv_n + 1;
      fv_t1 = fv_t2;
      fv_t2 = cyc;
    end
    if (frame_error) fe_n = fe_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclkin);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    logic acc;
    rx_valid = 1'b0;
    rx_data  = 8'h5A;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      ok = rx_ready;
      tick();
      if (ok) begin
        acc = 1'b1;
        break;
      end
    end
    chk("byte_accepted", {31'd0, acc}, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    send(8'hFF, 0);
    for (int i = 0; i < 6; i++) begin
      send(fw[i][15:8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      send(fw[i][7:0],  (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  task automatic chk_data(input string tag);
    for (int i = 0; i < 6; i++) chk(tag, {16'd0, dout[i]}, {16'd0, fw[i]});
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #3;
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    #3;
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_fe", {31'd0, frame_error}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_d0", {16'd0, data_adc_0}, 32'd0);
    chk("rst_d5", {16'd0, data_adc_5}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_ready", {31'd0, rx_ready}, 32'd1);

    // Nominal frame at full throughput
    fw = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0001, 16'hFFFE};
    send_frame(0);
    chk("nom_commit_ready", {31'd0, rx_ready}, 32'd0);
    chk("nom_fv_early", {31'd0, frame_valid}, 32'd0);
    tick();
    chk("nom_fv", {31'd0, frame_valid}, 32'd1);
    chk("nom_ready_back", {31'd0, rx_ready}, 32'd1);
    chk("nom_count", {16'd0, frame_count}, 32'd1);
    chk_data("nom_data");
    tick();
    chk("nom_fv_low", {31'd0, frame_valid}, 32'd0);

    // Garbage before header
    do_reset();
    send(8'h00, 0);
    send(8'h55, 0);
    send(8'hAA, 0);
    fw = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send_frame(0);
    repeat (2) tick();
    chk_data("garb_data");
    chk("garb_count", {16'd0, frame_count}, 32'd1);

    // Random idle gaps between bytes
    do_reset();
    fe_n = fe_n;
    begin
      int fe0;
      fe0 = fe_n;
      fw = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      send_frame(10);
      repeat (2) tick();
      chk_data("gap_data");
      chk("gap_count", {16'd0, frame_count}, 32'd1);
      chk("gap_no_err", fe_n - fe0, 32'd0);
    end

    // Stall mid-frame until timeout; outputs hold the previous good frame
    prev = fw;
    send(8'hFF, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 0);
    send(8'h78, 0);
    send(8'h9A, 0);
    repeat (TO - 2) tick();
    chk("to_err_early", {31'd0, frame_error}, 32'd0);
    tick();
    chk("to_err", {31'd0, frame_error}, 32'd1);
    chk("to_hunt_ready", {31'd0, rx_ready}, 32'd1);
    tick();
    chk("to_err_low", {31'd0, frame_error}, 32'd0);
    chk("to_count", {16'd0, frame_count}, 32'd1);
    fw = prev;
    chk_data("to_hold");
    fw = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2, 16'hE1E2, 16'hF1F2};
    send_frame(0);
    repeat (2) tick();
    chk_data("to_next_data");
    chk("to_next_count", {16'd0, frame_count}, 32'd2);

    // Back-to-back frames, second header offered during COMMIT
    do_reset();
    begin
      int fv0;
      fv0 = fv_n;
      fw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      send_frame(0);
      fw = '{16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1020, 16'h3040, 16'h5060};
      send_frame(0);
      repeat (3) tick();
      chk("b2b_pulses", fv_n - fv0, 32'd2);
      chk("b2b_period", fv_t2 - fv_t1, 32'd14);
      chk("b2b_count", {16'd0, frame_count}, 32'd2);
      chk_data("b2b_data");
    end

    // Reset asserted while payload byte 7 is on the bus
    send_frame(0);
    repeat (2) tick();
    chk("mid_pre_count", {16'd0, frame_count}, 32'd3);
    send(8'hFF, 0);
    for (int i = 0; i < 6; i++) send(8'h77, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #2 rst = 1'b0;
    #1;
    chk("mid_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_count", {16'd0, frame_count}, 32'd0);
    chk("mid_d0", {16'd0, data_adc_0}, 32'd0);
    chk("mid_d3", {16'd0, data_adc_3}, 32'd0);
    chk("mid_fv", {31'd0, frame_valid}, 32'd0);
    rx_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    fw = '{16'hCAFE, 16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};
    send_frame(0);
    repeat (2) tick();
    chk_data("mid_after_data");
    chk("mid_after_count", {16'd0, frame_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
